cpu_queue_state: RTL and testbench
==================================

// Module: cpu_queue_state
// PURPOSE
// Per-queue CPU ring-buffer state table feeding the FPGA->CPU PCIe DMA stage.
// Holds kmem_addr/head/tail for every application queue. On dma_start it looks up
// the queue named by dma_queue and presents head/tail/kmem_addr with queue_ready.
// On dma_done it writes back the DMA stage's out_tail. CPU updates head (and initialises queues) over an MMIO slave port.
// PARAMETERS
// NB_QUEUES      16  number of application queues (= 2**APP_IDX_WIDTH)
// APP_IDX_WIDTH  4   queue index width
// RB_AWIDTH      10  CPU ring-buffer slot index width (64B slots)
// PORTS
// clk            in   1             single clock, all logic on posedge
// rst            in   1             synchronous, active-high reset
// dma_start      in   1             DMA stage requests queue state
// dma_queue      in   APP_IDX_WIDTH queue index, stable while dma_start high
// dma_done       in   1             1-cycle pulse: transfer complete, out_tail valid
// out_tail       in   RB_AWIDTH     new tail to write back for active queue
// queue_ready    out  1             head/tail/kmem_addr valid for active queue
// head           out  RB_AWIDTH     active queue head (CPU consume pointer)
// tail           out  RB_AWIDTH     active queue tail (FPGA produce pointer)
// kmem_addr      out  64            active queue ring-buffer base address in host memory
// cfg_write      in   1             MMIO write strobe
// cfg_read       in   1             MMIO read strobe
// cfg_address    in   APP_IDX_WIDTH+2  {queue, reg}; reg 0=kmem_lo 1=kmem_hi 2=head 3=tail
// cfg_writedata  in   32            MMIO write data
// cfg_readdata   out  32            MMIO read data
// cfg_readvalid  out  1             read data valid, 1 cycle after cfg_read
// BEHAVIOUR
// - Reset: all table entries 0; queue_ready=0, head=tail=0, kmem_addr=0, cfg_readvalid=0, cfg_readdata=0, FSM=IDLE.
// - FSM: IDLE -> (dma_start) LOOKUP, latch dma_queue as act_q. LOOKUP -> READY after 1 cycle (registered table read).
//   READY: queue_ready=1 until dma_done. On dma_done: tail[act_q]<=out_tail, queue_ready=0 next cycle, -> IDLE.
// - Latency: dma_start sampled in cycle N -> queue_ready=1 in cycle N+2.
// - dma_start is sampled only in IDLE. It is ignored in LOOKUP/READY (simulation assertion fires).
// - dma_done outside READY: ignored, table unchanged, assertion fires.
// - dma_start in the cycle after dma_done is accepted. IDLE is reached in that cycle, so back-to-back transfers lose no cycle.
// - head output is live while READY: a CPU head write to act_q is visible on head the next cycle.
//   The DMA stage's free-space check then sees the freed slots.
// - kmem_addr and tail outputs are frozen from LOOKUP until IDLE. CPU writes to them update the table only.
// - Same-cycle CPU tail write and dma_done to the same queue: dma_done value wins.
// - Same-cycle CPU head write and dma_done to the same queue: both take effect (different fields).
// - Writes: head/tail take cfg_writedata[RB_AWIDTH-1:0], upper bits dropped.
//   kmem_lo/kmem_hi write the 32-bit halves of kmem_addr.
// - Reads: return the table value zero-extended to 32 bits. cfg_readvalid pulses 1 cycle after cfg_read.
//   A tail read returns the post-writeback value if dma_done was in the same cycle.
// - cfg_read and cfg_write in the same cycle are both serviced.
// - Reset mid-operation (any state): FSM->IDLE, queue_ready=0 next cycle, all table entries cleared.
// - No arithmetic on pointers here: wrap and free-slot math belong to the DMA stage.
// TESTING
// - Reset, then read all 4 regs of queue 5 -> all read 0, cfg_readvalid exactly 1 cycle after each cfg_read.
// - Write q3 kmem=0x1_0000_2000, head=7, then dma_start q3 at cycle N
//   -> queue_ready=1 at N+2, kmem_addr=0x100002000, head=7, tail=0.
// - In READY, dma_done with out_tail=12 -> queue_ready=0 next cycle, tail[3] reads 12.
//   dma_start q3 the following cycle presents tail=12.
// - In READY on q3, CPU writes head=20 -> head output=20 next cycle.
//   A kmem_lo write to q3 in READY leaves the kmem_addr output unchanged until IDLE.
// - Same cycle: dma_done(out_tail=9) + CPU tail write 4 to q3 -> tail[3]=9.
//   Same cycle with a q3 head write of 2 -> head[3]=2, tail[3]=9.
// - Assert rst during READY -> queue_ready=0 next cycle, every queue register reads 0, next dma_start behaves as post-reset.

Source files
------------

// File: rtl/cpu_queue_state.sv
// cpu_queue_state: per-queue host ring-buffer state (kmem_addr/head/tail) for the
// FPGA->CPU DMA stage. The DMA stage looks up one active queue at a time. The CPU
// initialises queues and advances head through a small MMIO slave port.
module cpu_queue_state #(
    parameter int unsigned NB_QUEUES     = 16,
    parameter int unsigned APP_IDX_WIDTH = 4,
    parameter int unsigned RB_AWIDTH     = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dma_start,
    input  logic [APP_IDX_WIDTH-1:0]   dma_queue,
    input  logic                       dma_done,
    input  logic [RB_AWIDTH-1:0]       out_tail,
    output logic                       queue_ready,
    output logic [RB_AWIDTH-1:0]       head,
    output logic [RB_AWIDTH-1:0]       tail,
    output logic [63:0]                kmem_addr,
    input  logic                       cfg_write,
    input  logic                       cfg_read,
    input  logic [APP_IDX_WIDTH+1:0]   cfg_address,
    input  logic [31:0]                cfg_writedata,
    output logic [31:0]                cfg_readdata,
    output logic                       cfg_readvalid
);

    typedef enum logic [1:0] {IDLE, LOOKUP, READY} state_t;

    state_t                     state_q, state_d;
    logic [APP_IDX_WIDTH-1:0]   act_q_q, act_q_d;

    logic [63:0]                kmem_tbl_q [NB_QUEUES];
    logic [RB_AWIDTH-1:0]       head_tbl_q [NB_QUEUES];
    logic [RB_AWIDTH-1:0]       tail_tbl_q [NB_QUEUES];

    logic [63:0]                kmem_out_q;
    logic [RB_AWIDTH-1:0]       tail_out_q;

    logic [31:0]                rdata_q, rdata_d;
    logic                       rvalid_q;

    logic [APP_IDX_WIDTH-1:0]   cfg_q;
    logic [1:0]                 cfg_reg;
    logic                       wb_en;

    assign cfg_q   = cfg_address[APP_IDX_WIDTH+1:2];
    assign cfg_reg = cfg_address[1:0];
    assign wb_en   = (state_q == READY) && dma_done;

    // Next-state logic: accept a lookup only in IDLE, return to IDLE on dma_done
    always_comb begin
        state_d = state_q;
        act_q_d = act_q_q;
        unique case (state_q)
            IDLE: begin
                if (dma_start) begin
                    state_d = LOOKUP;
                    act_q_d = dma_queue;
                end
            end
            LOOKUP:  state_d = READY;
            READY:   if (dma_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and active-queue register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            act_q_q <= '0;
        end else begin
            state_q <= state_d;
            act_q_q <= act_q_d;
        end
    end

    // State table: CPU writes first, DMA tail writeback last so it wins on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NB_QUEUES; i++) begin
                kmem_tbl_q[i] <= '0;
                head_tbl_q[i] <= '0;
                tail_tbl_q[i] <= '0;
            end
        end else begin
            if (cfg_write) begin
                unique case (cfg_reg)
                    2'd0: kmem_tbl_q[cfg_q][31:0]  <= cfg_writedata;
                    2'd1: kmem_tbl_q[cfg_q][63:32] <= cfg_writedata;
                    2'd2: head_tbl_q[cfg_q]        <= cfg_writedata[RB_AWIDTH-1:0];
                    default: tail_tbl_q[cfg_q]     <= cfg_writedata[RB_AWIDTH-1:0];
                endcase
            end
            if (wb_en) begin
                tail_tbl_q[act_q_q] <= out_tail;
            end
        end
    end

    // Registered lookup of kmem_addr/tail; held from the end of LOOKUP until the next lookup
    always_ff @(posedge clk) begin
        if (rst) begin
            kmem_out_q <= '0;
            tail_out_q <= '0;
        end else if (state_q == LOOKUP) begin
            kmem_out_q <= kmem_tbl_q[act_q_q];
            tail_out_q <= tail_tbl_q[act_q_q];
        end
    end

    // MMIO read mux; a tail read colliding with writeback returns the written-back value
    always_comb begin
        rdata_d = '0;
        unique case (cfg_reg)
            2'd0: rdata_d = kmem_tbl_q[cfg_q][31:0];
            2'd1: rdata_d = kmem_tbl_q[cfg_q][63:32];
            2'd2: rdata_d = {{(32-RB_AWIDTH){1'b0}}, head_tbl_q[cfg_q]};
            default: begin
                if (wb_en && (cfg_q == act_q_q))
                    rdata_d = {{(32-RB_AWIDTH){1'b0}}, out_tail};
                else
                    rdata_d = {{(32-RB_AWIDTH){1'b0}}, tail_tbl_q[cfg_q]};
            end
        endcase
    end

    // MMIO read response register: valid pulses one cycle after cfg_read
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= cfg_read;
            if (cfg_read) rdata_q <= rdata_d;
        end
    end

    assign queue_ready   = (state_q == READY);
    assign head          = head_tbl_q[act_q_q];
    assign tail          = tail_out_q;
    assign kmem_addr     = kmem_out_q;
    assign cfg_readdata  = rdata_q;
    assign cfg_readvalid = rvalid_q;

    a_start_in_idle: assert property (@(posedge clk) disable iff (rst)
        dma_start |-> (state_q == IDLE));
    a_done_in_ready: assert property (@(posedge clk) disable iff (rst)
        dma_done |-> (state_q == READY));

endmodule

// File: tb/tb_cpu_queue_state.sv
// Directed bench for cpu_queue_state: table of per-cycle vectors plus
// hand-written sequences for writeback bypass and mid-transfer reset.
module tb_cpu_queue_state;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_start;
    logic [3:0]  dma_queue;
    logic        dma_done;
    logic [9:0]  out_tail;
    logic        queue_ready;
    logic [9:0]  head;
    logic [9:0]  tail;
    logic [63:0] kmem_addr;
    logic        cfg_write;
    logic        cfg_read;
    logic [5:0]  cfg_address;
    logic [31:0] cfg_writedata;
    logic [31:0] cfg_readdata;
    logic        cfg_readvalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_queue_state #(
        .NB_QUEUES(16),
        .APP_IDX_WIDTH(4),
        .RB_AWIDTH(10)
    ) dut (
        .clk(clk), .rst(rst),
        .dma_start(dma_start), .dma_queue(dma_queue),
        .dma_done(dma_done), .out_tail(out_tail),
        .queue_ready(queue_ready), .head(head), .tail(tail), .kmem_addr(kmem_addr),
        .cfg_write(cfg_write), .cfg_read(cfg_read), .cfg_address(cfg_address),
        .cfg_writedata(cfg_writedata), .cfg_readdata(cfg_readdata),
        .cfg_readvalid(cfg_readvalid)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [5:0]  addr;
        logic [31:0] wd;
        logic        st;
        logic [3:0]  q;
        logic        done;
        logic [9:0]  ot;
        logic        e_rdy;
        logic [9:0]  e_head;
        logic [9:0]  e_tail;
        logic [63:0] e_kmem;
        logic        e_rv;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic [5:0] addr,
                       input logic [31:0] wd, input logic st, input logic [3:0] q,
                       input logic done, input logic [9:0] ot, input logic e_rdy,
                       input logic [9:0] e_head, input logic [9:0] e_tail,
                       input logic [63:0] e_kmem, input logic e_rv, input logic [31:0] e_rd);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wd = wd; v.st = st; v.q = q;
        v.done = done; v.ot = ot; v.e_rdy = e_rdy; v.e_head = e_head;
        v.e_tail = e_tail; v.e_kmem = e_kmem; v.e_rv = e_rv; v.e_rd = e_rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dma_start = 1'b0; dma_queue = '0; dma_done = 1'b0; out_tail = '0;
        cfg_write = 1'b0; cfg_read = 1'b0; cfg_address = '0; cfg_writedata = '0;
    endtask

    localparam logic [63:0] K1 = 64'h0000_0001_0000_2000;
    localparam logic [63:0] K2 = 64'h0000_0001_DEAD_0000;

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;

        chk("rst.ready",  64'(queue_ready),   64'd0);
        chk("rst.head",   64'(head),          64'd0);
        chk("rst.tail",   64'(tail),          64'd0);
        chk("rst.kmem",   kmem_addr,          64'd0);
        chk("rst.rvalid", 64'(cfg_readvalid), 64'd0);
        chk("rst.rdata",  64'(cfg_readdata),  64'd0);

        //   wr rd addr   wd            st q  dn ot   rdy head tail kmem   rv rd
        add(0, 1, 6'h14, 0,            0, 0, 0, 0,   0,  0,   0,   0,     1, 0);
        add(0, 1, 6'h15, 0,            0, 0, 0, 0,   0,  0,   0,   0,     1, 0);
        add(0, 1, 6'h16, 0,            0, 0, 0, 0,   0,  0,   0,   0,     1, 0);
        add(0, 1, 6'h17, 0,            0, 0, 0, 0,   0,  0,   0,   0,     1, 0);
        add(0, 0, 6'h00, 0,            0, 0, 0, 0,   0,  0,   0,   0,     0, 0);
        add(1, 0, 6'h0C, 32'h2000,     0, 0, 0, 0,   0,  0,   0,   0,     0, 0);
        add(1, 0, 6'h0D, 32'h1,        0, 0, 0, 0,   0,  0,   0,   0,     0, 0);
        add(1, 0, 6'h0E, 32'h407,      0, 0, 0, 0,   0,  0,   0,   0,     0, 0);
        add(0, 1, 6'h0E, 0,            0, 0, 0, 0,   0,  0,   0,   0,     1, 7);
        add(0, 0, 6'h00, 0,            1, 3, 0, 0,   0,  7,   0,   0,     0, 0);
        add(0, 0, 6'h00, 0,            0, 0, 0, 0,   1,  7,   0,   K1,    0, 0);
        add(0, 0, 6'h00, 0,            0, 0, 0, 0,   1,  7,   0,   K1,    0, 0);
        add(1, 0, 6'h0E, 32'd20,       0, 0, 0, 0,   1,  20,  0,   K1,    0, 0);
        add(1, 0, 6'h0C, 32'hDEAD0000, 0, 0, 0, 0,   1,  20,  0,   K1,    0, 0);
        add(0, 0, 6'h00, 0,            0, 0, 1, 12,  0,  20,  0,   K1,    0, 0);
        add(0, 1, 6'h0F, 0,            1, 3, 0, 0,   0,  20,  0,   K1,    1, 12);
        add(0, 1, 6'h0C, 0,            0, 0, 0, 0,   1,  20,  12,  K2,    1, 32'hDEAD0000);
        add(1, 0, 6'h0F, 32'd4,        0, 0, 1, 9,   0,  20,  12,  K2,    0, 0);
        add(0, 1, 6'h0F, 0,            0, 0, 0, 0,   0,  20,  12,  K2,    1, 9);
        add(0, 0, 6'h00, 0,            1, 3, 0, 0,   0,  20,  12,  K2,    0, 0);
        add(0, 0, 6'h00, 0,            0, 0, 0, 0,   1,  20,  9,   K2,    0, 0);
        add(1, 0, 6'h0E, 32'd2,        0, 0, 1, 9,   0,  2,   9,   K2,    0, 0);
        add(0, 1, 6'h0E, 0,            0, 0, 0, 0,   0,  2,   9,   K2,    1, 2);
        add(0, 1, 6'h0F, 0,            0, 0, 0, 0,   0,  2,   9,   K2,    1, 9);

        for (int i = 0; i < vecs.size(); i++) begin
            cfg_write = vecs[i].wr; cfg_read = vecs[i].rd;
            cfg_address = vecs[i].addr; cfg_writedata = vecs[i].wd;
            dma_start = vecs[i].st; dma_queue = vecs[i].q;
            dma_done = vecs[i].done; out_tail = vecs[i].ot;
            tick();
            chk($sformatf("v%0d.ready", i),  64'(queue_ready),   64'(vecs[i].e_rdy));
            chk($sformatf("v%0d.head", i),   64'(head),          64'(vecs[i].e_head));
            chk($sformatf("v%0d.tail", i),   64'(tail),          64'(vecs[i].e_tail));
            chk($sformatf("v%0d.kmem", i),   kmem_addr,          vecs[i].e_kmem);
            chk($sformatf("v%0d.rvalid", i), 64'(cfg_readvalid), 64'(vecs[i].e_rv));
            if (vecs[i].e_rv)
                chk($sformatf("v%0d.rdata", i), 64'(cfg_readdata), 64'(vecs[i].e_rd));
        end
        idle_inputs();

        // Tail read in the same cycle as writeback sees the new tail
        dma_start = 1'b1; dma_queue = 4'd3;
        tick();
        idle_inputs();
        tick();
        chk("byp.ready", 64'(queue_ready), 64'd1);
        chk("byp.tail",  64'(tail),        64'd9);
        dma_done = 1'b1; out_tail = 10'd33; cfg_read = 1'b1; cfg_address = 6'h0F;
        tick();
        idle_inputs();
        chk("byp.rvalid", 64'(cfg_readvalid), 64'd1);
        chk("byp.rdata",  64'(cfg_readdata),  64'd33);
        chk("byp.idle",   64'(queue_ready),   64'd0);

        // Reset while READY clears everything
        dma_start = 1'b1; dma_queue = 4'd3;
        tick();
        idle_inputs();
        tick();
        chk("rr.ready_before", 64'(queue_ready), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr.ready", 64'(queue_ready), 64'd0);
        chk("rr.head",  64'(head),        64'd0);
        chk("rr.tail",  64'(tail),        64'd0);
        chk("rr.kmem",  kmem_addr,        64'd0);
        for (int qq = 0; qq < 16; qq++) begin
            for (int r = 0; r < 4; r++) begin
                cfg_read = 1'b1;
                cfg_address = 6'((qq << 2) | r);
                tick();
                chk($sformatf("rr.rv.q%0d.r%0d", qq, r), 64'(cfg_readvalid), 64'd1);
                chk($sformatf("rr.rd.q%0d.r%0d", qq, r), 64'(cfg_readdata),  64'd0);
            end
        end
        idle_inputs();
        tick();
        chk("rr.rvalid_drop", 64'(cfg_readvalid), 64'd0);
        dma_start = 1'b1; dma_queue = 4'd3;
        tick();
        idle_inputs();
        chk("rr.lookup_ready", 64'(queue_ready), 64'd0);
        tick();
        chk("rr.post.ready", 64'(queue_ready), 64'd1);
        chk("rr.post.kmem",  kmem_addr,        64'd0);
        chk("rr.post.head",  64'(head),        64'd0);
        chk("rr.post.tail",  64'(tail),        64'd0);
        dma_done = 1'b1; out_tail = 10'd1;
        tick();
        idle_inputs();
        chk("rr.post.done", 64'(queue_ready), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
